display_scan_mux: RTL and testbench
===================================

Name: display_scan_mux

Overview:
- Upstream feeder for the 7-segment decoder in a multiplexed multi-digit display.
- Latches a packed BCD value and time-multiplexes it one digit at a time onto the decoder's 4-bit D input.
- Drives the active-low common digit enables (AN) so that they switch in step with the decoder's registered SEG output.
- Optionally blanks leading zeros.

Parameters:
- DIGITS, 4: number of display digits, range 2..8.
- REFRESH_DIV, 50000: clock cycles each digit stays selected, minimum 2.

Ports:
- CLK, input, 1: system clock, rising edge.
- RST_N, input, 1: asynchronous active-low reset.
- LOAD, input, 1: single-cycle strobe that captures VALUE.
- VALUE, input, 4*DIGITS: packed BCD. Nibble k (bits 4k+3..4k) is digit k; digit 0 is least significant.
- BLANK_LZ, input, 1: 1 enables leading-zero blanking.
- D, output, 4: digit code to the 7-segment decoder. 4'hF means blank.
- AN, output, DIGITS: active-low digit enables, one-hot-low, aligned with the decoder's SEG.
- FRAME, output, 1: one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

Behaviour:
- Reset (RST_N low, asynchronous) forces:
  - prescaler = 0, idx = 0, idx_d = 0
  - shadow register = 0
  - D = 4'hF, AN = all ones (all digits off), FRAME = 0
- Reset mid-scan aborts immediately. After release, scanning restarts at digit 0 with a fresh prescaler.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick = (prescaler == REFRESH_DIV-1).
- Digit index idx:
  - Increments on tick.
  - Wraps from DIGITS-1 to 0.
  - FRAME = 1 in the cycle after the wrap tick (registered), otherwise 0.
- Shadow register:
  - LOAD=1 at a rising edge captures VALUE into shadow.
  - The new value affects D from the next cycle.
  - LOAD does not reset the prescaler or idx.
  - Back-to-back LOADs: the last one wins.
- Leading-zero blanking:
  - lz_limit = index of the most significant nonzero nibble in shadow. lz_limit = 0 when all nibbles are zero.
  - When BLANK_LZ=1 and idx > lz_limit, the selected code is 4'hF.
  - Digit 0 is never blanked; an all-zero value displays a single "0".
  - Only nibble value 0 counts as zero. Nibbles 0xA..0xF count as nonzero and pass through unchanged (the decoder blanks them).
  - BLANK_LZ is sampled every cycle, with no latching.
- Output timing:
  - D <= selected code for idx. D is registered: 1-cycle latency from idx.
  - idx_d <= idx.
  - AN <= ~(1 << idx_d). AN changes exactly 2 cycles after idx changes.
  - This matches the D register plus the decoder's SEG register, so segment data and digit enable switch in the same cycle with no ghosting.
  - In the first cycle after reset release, AN stays all ones. In the second cycle it becomes ~1 (digit 0 enabled).
- Width rules:
  - Prescaler width = clog2(REFRESH_DIV).
  - idx width = clog2(DIGITS), minimum 1.
  - For non-power-of-2 DIGITS, idx never exceeds DIGITS-1.
- Simultaneous events:
  - LOAD coinciding with tick: idx advances and the shadow updates in the same edge.
  - D in the following cycle uses the new digit and the new value.

Test Plan (DIGITS=4, REFRESH_DIV=4):
- Reset/pipeline alignment:
  - Stimulus: hold RST_N=0, then release, no LOAD.
  - Required: D=F and AN=1111 during reset. After release, D=0 on cycle 1, AN=1110 from cycle 2, AN=1101 from cycle 6.
- Basic scan:
  - Stimulus: LOAD VALUE=16'h1234, BLANK_LZ=0.
  - Required: D sequence 4,3,2,1, each digit held 4 cycles. AN trails D by 1 cycle: 1110, 1101, 1011, 0111. FRAME pulses once every 16 cycles.
- Leading-zero blanking:
  - Stimulus: VALUE=16'h0042, BLANK_LZ=1.
  - Required: D sequence 2,4,F,F.
  - Stimulus: VALUE=16'h0000.
  - Required: D sequence 0,F,F,F.
  - Stimulus: BLANK_LZ=0 with VALUE=16'h0042.
  - Required: D sequence 2,4,0,0.
- Non-BCD passthrough:
  - Stimulus: VALUE=16'h0A00, BLANK_LZ=1.
  - Required: D sequence 0,0,A,F.
- LOAD mid-digit and at tick:
  - Stimulus: LOAD 16'h5678 in the cycle after the 16'h1234 scan reaches digit 2.
  - Required: D becomes 6 on the next cycle, with no prescaler restart.
  - Stimulus: LOAD coincident with tick.
  - Required: the next digit shows the new value.
- Asynchronous reset mid-scan:
  - Stimulus: assert RST_N=0 between clock edges while idx=3.
  - Required: D=F and AN=1111 immediately, without waiting for a clock edge. After release, the scan restarts at digit 0 and shadow=0.

Source files
------------

// File: rtl/display_scan_mux.sv
// Scan multiplexer for a multi-digit 7-segment display: latches a packed BCD value and
// presents it one digit at a time to the decoder, with digit enables aligned to SEG.
module display_scan_mux #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   VALUE,
    input  logic                  BLANK_LZ,
    output logic [3:0]            D,
    output logic [DIGITS-1:0]     AN,
    output logic                  FRAME
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [IW-1:0]         idx_dly_q, idx_dly_d;
    logic [4*DIGITS-1:0]   shadow_q, shadow_d;
    logic [3:0]            d_q, d_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  frame_q, frame_d;
    logic                  an_en_q, an_en_d;

    logic                  tick;
    logic [IW-1:0]         lz_limit;
    logic [3:0]            nib;

    always_comb begin
        tick      = (presc_q == PRESC_MAX);
        presc_d   = tick ? '0 : presc_q + 1'b1;
        idx_d     = idx_q;
        frame_d   = 1'b0;
        if (tick) begin
            if (idx_q == LAST_IDX) begin
                idx_d   = '0;
                frame_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        shadow_d = LOAD ? VALUE : shadow_q;

        // lz_limit ends at the most significant nonzero nibble; digit 0 is never blanked.
        lz_limit = '0;
        nib      = 4'h0;
        for (int k = 0; k < DIGITS; k++) begin
            if (shadow_q[4*k +: 4] != 4'h0) begin
                lz_limit = IW'(k);
            end
            if (idx_q == IW'(k)) begin
                nib = shadow_q[4*k +: 4];
            end
        end
        d_d = (BLANK_LZ && (idx_q > lz_limit)) ? 4'hF : nib;

        // AN lags idx by two registers to match D plus the decoder's SEG register;
        // an_en keeps all digits dark until the delayed index is meaningful.
        idx_dly_d = idx_q;
        an_en_d   = 1'b1;
        an_d      = '1;
        for (int k = 0; k < DIGITS; k++) begin
            an_d[k] = ~(an_en_q && (idx_dly_q == IW'(k)));
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc_q   <= '0;
            idx_q     <= '0;
            idx_dly_q <= '0;
            shadow_q  <= '0;
            d_q       <= 4'hF;
            an_q      <= '1;
            frame_q   <= 1'b0;
            an_en_q   <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            idx_dly_q <= idx_dly_d;
            shadow_q  <= shadow_d;
            d_q       <= d_d;
            an_q      <= an_d;
            frame_q   <= frame_d;
            an_en_q   <= an_en_d;
        end
    end

    assign D     = d_q;
    assign AN    = an_q;
    assign FRAME = frame_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux (4 digits, 4-cycle refresh): a time-indexed reference model
// checked every cycle, plus directed scenarios with literal expected values.
module tb_display_scan_mux;

    localparam int NDIG = 4;
    localparam int RDIV = 4;
    localparam int EW   = 1 + NDIG + 4;
    localparam logic [EW-1:0] RESET_EXP = {1'b0, 4'b1111, 4'hF};

    logic              clk;
    logic              rst_n;
    logic              load;
    logic [4*NDIG-1:0] value;
    logic              blank_lz;
    logic [3:0]        d_out;
    logic [NDIG-1:0]   an_out;
    logic              frame_out;

    int n_checks = 0;
    int n_pass   = 0;
    logic [EW-1:0] exp_q[$];

    display_scan_mux #(.DIGITS(NDIG), .REFRESH_DIV(RDIV)) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .LOAD     (load),
        .VALUE    (value),
        .BLANK_LZ (blank_lz),
        .D        (d_out),
        .AN       (an_out),
        .FRAME    (frame_out)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference: digit shown is a pure function of the shadow value and the blanking rule.
    function automatic logic [3:0] model_digit(input int idx, input logic [15:0] v, input logic blank);
        int msd;
        msd = 0;
        for (int k = 0; k < NDIG; k++) if (v[4*k +: 4] != 4'h0) msd = k;
        if (blank && idx > msd) return 4'hF;
        return v[4*idx +: 4];
    endfunction

    // Scan position after t clocks since reset release.
    function automatic int idx_at(input int t);
        return (t / RDIV) % NDIG;
    endfunction

    // model: predicts outputs for the cycle following each rising edge
    initial begin
        int t;
        logic [15:0] m_shadow;
        logic [3:0]  an_exp;
        logic        fr_exp;
        t = 0;
        m_shadow = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                t = 0;
                m_shadow = '0;
                exp_q.delete();
            end else begin
                an_exp = 4'b1111;
                if (t + 1 >= 2) an_exp[idx_at(t - 1)] = 1'b0;
                fr_exp = ((t + 1) % (RDIV * NDIG) == 0);
                exp_q.push_back({fr_exp, an_exp, model_digit(idx_at(t), m_shadow, blank_lz)});
                if (load) m_shadow = value;
                t++;
            end
        end
    end

    // scoreboard compare, away from the active edge
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : RESET_EXP;
            check("scan_cmp", 16'({frame_out, an_out, d_out}), 16'(e));
        end
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        load  = 1'b1;
        value = v;
        step(1);
        load  = 1'b0;
    endtask

    task automatic wait_frame();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step(1);
            if (frame_out) seen = 1'b1;
        end
        if (!seen) check("frame_timeout", 16'd0, 16'd1);
    endtask

    // Sample the digit code shown for each digit of one full scan.
    task automatic grab_frame(output logic [15:0] got);
        wait_frame();
        for (int k = 0; k < NDIG; k++) begin
            step(k == 0 ? 1 : RDIV);
            got[4*k +: 4] = d_out;
        end
    endtask

    logic [15:0] got;
    int          nframes;
    logic [3:0]  an_tab [1:6];

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = '0;
        blank_lz = 1'b0;
        an_tab[1] = 4'b1111; an_tab[2] = 4'b1110; an_tab[3] = 4'b1110;
        an_tab[4] = 4'b1110; an_tab[5] = 4'b1110; an_tab[6] = 4'b1101;

        // reset and pipeline alignment
        step(2);
        check("rst_d", 16'(d_out), 16'hF);
        check("rst_an", 16'(an_out), 16'hF);
        check("rst_frame", 16'(frame_out), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step(1);
            if (c == 1) check("rel_d_c1", 16'(d_out), 16'h0);
            check($sformatf("rel_an_c%0d", c), 16'(an_out), 16'(an_tab[c]));
        end

        // basic scan
        do_load(16'h1234);
        grab_frame(got);
        check("scan_1234", got, 16'h1234);
        nframes = 0;
        for (int i = 0; i < 32; i++) begin
            step(1);
            if (frame_out) nframes++;
        end
        check("frame_count", 16'(nframes), 16'd2);

        // leading-zero blanking
        blank_lz = 1'b1;
        do_load(16'h0042);
        grab_frame(got);
        check("lz_0042", got, 16'hFF42);
        do_load(16'h0000);
        grab_frame(got);
        check("lz_0000", got, 16'hFFF0);
        blank_lz = 1'b0;
        do_load(16'h0042);
        grab_frame(got);
        check("nolz_0042", got, 16'h0042);

        // non-BCD nibble counts as nonzero
        blank_lz = 1'b1;
        do_load(16'h0A00);
        grab_frame(got);
        check("lz_0a00", got, 16'hFA00);

        // LOAD mid-digit: frame at t, digit 2 selected from t+8, load during t+9
        blank_lz = 1'b0;
        do_load(16'h1234);
        wait_frame();
        step(9);
        load  = 1'b1;
        value = 16'h5678;
        step(1);
        load  = 1'b0;
        check("mid_load_old", 16'(d_out), 16'h2);
        step(1);
        check("mid_load_new", 16'(d_out), 16'h6);
        step(1);
        check("mid_load_hold", 16'(d_out), 16'h6);
        step(1);
        check("mid_load_next", 16'(d_out), 16'h5);

        // LOAD coincident with tick: cycle t+3 is the 0->1 tick
        wait_frame();
        step(3);
        load  = 1'b1;
        value = 16'h9876;
        step(1);
        load  = 1'b0;
        check("tick_load_cur", 16'(d_out), 16'h8);
        step(1);
        check("tick_load_next", 16'(d_out), 16'h7);

        // asynchronous reset while idx = 3
        wait_frame();
        step(13);
        #2 rst_n = 1'b0;
        #1;
        check("async_d", 16'(d_out), 16'hF);
        check("async_an", 16'(an_out), 16'hF);
        check("async_frame", 16'(frame_out), 16'h0);
        step(2);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        check("restart_d", 16'(d_out), 16'h0);
        step(1);
        check("restart_an", 16'(an_out), 16'hE);
        blank_lz = 1'b1;
        grab_frame(got);
        check("restart_shadow", got, 16'hFFF0);

        step(4);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
